bcd_counter_7seg_n: RTL
=======================

Name: bcd_counter_7seg_n

Overview:
Parametrised successor to the two-digit prescaled decimal counter with 7-segment output. It counts in N BCD digits, up or down, at C/2^PRESCALE_BITS when enabled. It supports synchronous parallel load and a terminal-count pulse. It drives one time-multiplexed 7-segment display bus with one-hot digit select, and it exposes the raw BCD value for the LED bank.

Parameters:
DIGITS, 2, number of BCD digits (1..8)
PRESCALE_BITS, 15, prescaler width; count tick every 2^PRESCALE_BITS enabled clocks (>=1)
SCAN_BITS, 10, scan divider width; display advances one digit every 2^SCAN_BITS clocks (>=1)

Ports:
C  in  1  clock, rising edge
CLR  in  1  asynchronous reset, active-high
CE  in  1  count enable; freezes prescaler and counter when 0
UP_DN  in  1  1 = count up, 0 = count down; sampled on the tick cycle
LOAD  in  1  synchronous parallel load
LOAD_VAL  in  4*DIGITS  BCD load value, digit 0 in [3:0]
BCD_OUT  out  4*DIGITS  current count, digit 0 in [3:0]
TC  out  1  terminal-count pulse
SEG  out  8  segment pattern, bit order Dgfedcba, active-high
DIG_SEL  out  DIGITS  one-hot digit enable, bit 0 = digit 0

Behaviour:
- One clock C. CLR is asynchronous and active-high. It clears all state immediately, regardless of C.
- Reset values:
  - prescaler 0, all count digits 0, BCD_OUT 0, TC 0.
  - scan divider 0, scan index 0.
  - DIG_SEL = 1 (digit 0 selected), SEG = 8'h3F.
- Prescaler:
  - Increments by 1 modulo 2^PRESCALE_BITS on each C edge with CE=1 and LOAD=0.
  - tick = CE & ~LOAD & (prescaler == all-ones). The count therefore steps on the clock edge where the prescaler wraps to 0.
- Count step on tick, UP_DN=1:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - Carry ripples combinationally within the same cycle, so all digits update on one edge.
- Count step on tick, UP_DN=0:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
- Wrap-around:
  - Up from all-9s gives all-0s.
  - Down from all-0s gives all-9s.
  - On either wrap, TC=1 for exactly one cycle. TC is registered: it is high in the cycle after the wrapping edge, coincident with the new BCD_OUT.
- LOAD:
  - LOAD=1 loads LOAD_VAL into the digits and clears the prescaler to 0, independent of CE.
  - LOAD has priority over tick, and no tick/TC is generated in that cycle.
  - Any nibble >9 in LOAD_VAL is loaded as 0; the other nibbles are unaffected.
- CE=0: prescaler and digits hold; LOAD and display scan remain active.
- BCD_OUT is a direct register output with 0 extra latency. The digit registers always hold valid BCD (0..9).
- Display scan (free-running, independent of CE and LOAD):
  - The scan divider increments every clock.
  - When it wraps, the scan index advances 0,1,...,DIGITS-1,0.
- SEG and DIG_SEL are registered together from the new scan index in the same cycle, so they are always aligned:
  - DIG_SEL = 1 << index.
  - SEG = decode(digit[index]), using the value current at the registering edge.
  - With DIGITS=1, DIG_SEL stays 1 and SEG still refreshes every scan step.
- Decode table, SEG[7]=0 always:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Values A..F are unreachable; SEG=00 (blank) if ever present.
- Reset mid-count or mid-scan: all state returns to reset values asynchronously. Counting resumes from prescaler 0 on the first edge after CLR falls.

Test Plan:
- Reset, CE=1, UP_DN=1, DIGITS=2, PRESCALE_BITS=2: CLR pulse → BCD_OUT=8'h00, DIG_SEL=2'b01, SEG=8'h3F, TC=0. After 4 clocks BCD_OUT=8'h01; after 40 clocks BCD_OUT=8'h10.
- LOAD_VAL=8'h98, LOAD one cycle, then CE=1 UP: after 8 clocks BCD_OUT=8'h00, and TC=1 for one cycle exactly when BCD_OUT becomes 8'h00.
- Down count from 8'h00 (UP_DN=0): after 4 clocks BCD_OUT=8'h99 with a TC pulse. After 4 more clocks BCD_OUT=8'h98, TC=0.
- CE=0 for 20 clocks mid-count → BCD_OUT and prescaler unchanged. LOAD_VAL=8'hA7 with CE=0 → BCD_OUT=8'h07.
- LOAD asserted on the same cycle as a tick with LOAD_VAL=8'h42 → BCD_OUT=8'h42, no increment, no TC. The next tick comes 4 enabled clocks later (8'h43).
- SCAN_BITS=1, BCD_OUT=8'h59 held: DIG_SEL alternates 01/10 every 2 clocks with SEG 6F/6D respectively. Then assert CLR mid-scan → DIG_SEL=01 and SEG=3F immediately.

Source files
------------

// File: rtl/bcd_counter_7seg_n.sv
// bcd_counter_7seg_n: N-digit prescaled BCD up/down counter with load, terminal count and multiplexed 7-segment output
module bcd_counter_7seg_n #(
  parameter int DIGITS = 2,
  parameter int PRESCALE_BITS = 15,
  parameter int SCAN_BITS = 10
) (
  input  logic                  C,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic                  UP_DN,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   BCD_OUT,
  output logic                  TC,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     DIG_SEL
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0] LUT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [PRESCALE_BITS-1:0] presc;
  logic [SCAN_BITS-1:0] sdiv;
  logic [IW-1:0] idx, nidx;
  logic [4*DIGITS-1:0] stepped, loadv;
  logic [3:0] d, ld;
  logic c, tick;
  // carry/borrow ripples through every digit so the whole count steps on one edge
  always_comb begin
    c = 1'b1;
    d = '0;
    ld = '0;
    stepped = BCD_OUT;
    loadv = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = BCD_OUT[4*i +: 4];
      stepped[4*i +: 4] = !c ? d : UP_DN ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
      c = c & (UP_DN ? d == 4'd9 : d == 4'd0);
      ld = LOAD_VAL[4*i +: 4];
      loadv[4*i +: 4] = ld > 4'd9 ? 4'd0 : ld;
    end
  end
  assign tick = CE & ~LOAD & (&presc);
  assign nidx = idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      presc <= '0;
      BCD_OUT <= '0;
      TC <= 1'b0;
      sdiv <= '0;
      idx <= '0;
      DIG_SEL <= DIGITS'(1);
      SEG <= 8'h3F;
    end else begin
      TC <= tick & c;
      sdiv <= sdiv + 1'b1;
      if (LOAD) begin
        BCD_OUT <= loadv;
        presc <= '0;
      end else if (CE) begin
        presc <= presc + 1'b1;
        if (tick) BCD_OUT <= stepped;
      end
      if (&sdiv) begin
        idx <= nidx;
        DIG_SEL <= DIGITS'(1) << nidx;
        SEG <= LUT[BCD_OUT[{nidx, 2'b00} +: 4]];
      end
    end
  end
endmodule
